// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: MIPS opcode/funct encodings, fetch entry type and fetch FSM states.
package ifetch_unit_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory, redirect and decode-side signals of the fetch stage.
interface ifetch_unit_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic excp;
  logic dec_ready;
  logic dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [5:0] opCode;
  logic [5:0] funct;
  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, opCode, funct,
    input imem_rdata, redirect_valid, redirect_pc, excp, dec_ready
  );
  modport slave (
    input imem_req, imem_addr, dec_valid, dec_instr, dec_pc, opCode, funct,
    output imem_rdata, redirect_valid, redirect_pc, excp, dec_ready
  );
endinterface

// File: rtl/ifetch_unit_fifo.sv
// ifetch_unit_fifo: prefetch FIFO of fetch_entry_t with synchronous flush and occupancy count.
module ifetch_unit_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem_q[wptr_q] <= din;
  assign dout = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, fetches from imem into a prefetch FIFO, flushes on redirect/exception.
// Define IFETCH_EPC_EN to add the epc output that captures the PC of the excepting instruction.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic reset,
`ifdef IFETCH_EPC_EN
  output logic [31:0] epc,
`endif
  ifetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, target;
  logic inflight_q, inflight_ep_q, epoch_q, epoch_d;
  logic excp_take, flush, pop, push, credit;
  logic [CW-1:0] count;
  fetch_entry_t head;
  always_comb begin
    bus.dec_valid = state_q == RUN && count != '0;
    bus.dec_instr = bus.dec_valid ? head.instr : NOP_INSTR;
    bus.dec_pc = bus.dec_valid ? head.pc : '0;
    bus.opCode = bus.dec_instr[31:26];
    bus.funct = bus.dec_instr[5:0];
    excp_take = state_q == RUN && bus.excp && bus.dec_valid;
    flush = excp_take || (state_q == RUN && bus.redirect_valid);
    target = excp_take ? EXC_VECTOR : {bus.redirect_pc[31:2], 2'b00};
    pop = bus.dec_valid && bus.dec_ready && !flush;
    // a response tagged with a stale epoch belongs to a squashed fetch stream
    push = inflight_q && inflight_ep_q == epoch_q && !flush;
    // a pop this cycle frees a slot for the word that returns next cycle
    credit = 32'(count) + 32'(inflight_q) < 32'(FIFO_DEPTH) + 32'(pop);
    bus.imem_req = credit && (state_q == FLUSH || (state_q == RUN && !flush));
    bus.imem_addr = fetch_pc_q;
    state_d = flush ? FLUSH : RUN;
    fetch_pc_d = flush ? target : bus.imem_req ? fetch_pc_q + 32'd4 : fetch_pc_q;
    epoch_d = epoch_q ^ flush;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= BOOT;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_ep_q <= 1'b0;
      inflight_pc_q <= '0;
      epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= bus.imem_req;
      inflight_ep_q <= epoch_q;
      inflight_pc_q <= fetch_pc_q;
      epoch_q <= epoch_d;
    end
`ifdef IFETCH_EPC_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) epc <= '0;
    else if (excp_take) epc <= bus.dec_pc;
`endif
  ifetch_unit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din('{pc: inflight_pc_q, instr: bus.imem_rdata}),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of fetch latency, backpressure, redirect, exception, PC wrap and reset.
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int passed = 0;
`ifdef IFETCH_EPC_EN
  logic [31:0] epc;
`endif
  ifetch_unit_if bus ();
  ifetch_unit dut (
    .clk(clk),
    .reset(reset),
`ifdef IFETCH_EPC_EN
    .epc(epc),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  // word at 0x108 is an illegal opcode; everything else returns its word index
  always @(posedge clk)
    if (bus.imem_req) bus.imem_rdata <= (bus.imem_addr == 32'h108) ? 32'hFC00_0000 : bus.imem_addr >> 2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic nx();
    @(negedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    bus.dec_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.excp = 1'b0;
    nx();
    nx();
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.dec_valid), 0);
    chk("rst_instr", bus.dec_instr, 0);
    chk("rst_pc", bus.dec_pc, 0);
    chk("rst_op", 32'(bus.opCode), 0);
    chk("rst_funct", 32'(bus.funct), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot_req", 32'(bus.imem_req), 0);
    nx();
    chk("c1_req", 32'(bus.imem_req), 1);
    chk("c1_addr", bus.imem_addr, 32'h0);
    chk("c1_valid", 32'(bus.dec_valid), 0);
    nx();
    chk("c2_addr", bus.imem_addr, 32'h4);
    chk("c2_valid", 32'(bus.dec_valid), 0);
    nx();
    chk("c3_valid", 32'(bus.dec_valid), 1);
    chk("c3_pc", bus.dec_pc, 32'h0);
    nx();
    chk("c4_pc", bus.dec_pc, 32'h4);
    chk("c4_instr", bus.dec_instr, 32'h1);
    chk("c4_funct", 32'(bus.funct), 1);
    nx();
    chk("c5_pc", bus.dec_pc, 32'h8);
    nx();
    chk("c6_pc", bus.dec_pc, 32'hC);
    bus.dec_ready = 1'b0;
    #1;
    chk("stall_req0", 32'(bus.imem_req), 0);
    nx();
    nx();
    chk("stall_pc", bus.dec_pc, 32'hC);
    chk("stall_req", 32'(bus.imem_req), 0);
    nx();
    nx();
    chk("stall_valid", 32'(bus.dec_valid), 1);
    chk("stall_pc2", bus.dec_pc, 32'hC);
    chk("stall_instr", bus.dec_instr, 32'h3);
    chk("stall_addr", bus.imem_addr, 32'h14);
    nx();
    bus.dec_ready = 1'b1;
    #1;
    chk("rel_pc", bus.dec_pc, 32'hC);
    chk("rel_req", 32'(bus.imem_req), 1);
    nx();
    chk("rel_pc1", bus.dec_pc, 32'h10);
    nx();
    chk("rel_pc2", bus.dec_pc, 32'h14);
    nx();
    chk("rel_pc3", bus.dec_pc, 32'h18);
    nx();
    chk("pre_redir_pc", bus.dec_pc, 32'h1C);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    #1;
    chk("redir_req", 32'(bus.imem_req), 0);
    nx();
    bus.redirect_valid = 1'b0;
    #1;
    chk("flush_valid", 32'(bus.dec_valid), 0);
    chk("flush_req", 32'(bus.imem_req), 1);
    chk("flush_addr", bus.imem_addr, 32'h100);
    nx();
    chk("redir_stale", 32'(bus.dec_valid), 0);
    nx();
    chk("redir_pc", bus.dec_pc, 32'h100);
    chk("redir_instr", bus.dec_instr, 32'h40);
    nx();
    chk("redir_pc1", bus.dec_pc, 32'h104);
    nx();
    chk("ill_instr", bus.dec_instr, 32'hFC00_0000);
    chk("ill_op", 32'(bus.opCode), 32'h3F);
    chk("ill_pc", bus.dec_pc, 32'h108);
    bus.excp = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    #1;
    chk("excp_req", 32'(bus.imem_req), 0);
    nx();
    bus.excp = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("excp_addr", bus.imem_addr, 32'h80);
`ifdef IFETCH_EPC_EN
    chk("epc", epc, 32'h108);
`endif
    nx();
    bus.excp = 1'b1;
    #1;
    chk("excp_novalid", 32'(bus.dec_valid), 0);
    nx();
    bus.excp = 1'b0;
    #1;
    chk("excp_pc", bus.dec_pc, 32'h80);
    chk("excp_instr", bus.dec_instr, 32'h20);
    nx();
    chk("excp_pc1", bus.dec_pc, 32'h84);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    #1;
    nx();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    nx();
    chk("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    nx();
    chk("wrap_addr2", bus.imem_addr, 32'h0);
    chk("wrap_req2", 32'(bus.imem_req), 1);
    chk("wrap_pc0", bus.dec_pc, 32'hFFFF_FFF8);
    nx();
    chk("wrap_pc1", bus.dec_pc, 32'hFFFF_FFFC);
    chk("wrap_instr1", bus.dec_instr, 32'h3FFF_FFFF);
    nx();
    chk("wrap_pc2", bus.dec_pc, 32'h0);
    bus.dec_ready = 1'b0;
    nx();
    chk("full_pc", bus.dec_pc, 32'h0);
    chk("full_req", 32'(bus.imem_req), 0);
    nx();
    bus.dec_ready = 1'b1;
    #1;
    chk("full_pop_req", 32'(bus.imem_req), 1);
    chk("full_pop_addr", bus.imem_addr, 32'h8);
    reset = 1'b1;
    #1;
    chk("arst_req", 32'(bus.imem_req), 0);
    chk("arst_valid", 32'(bus.dec_valid), 0);
    chk("arst_pc", bus.dec_pc, 32'h0);
    chk("arst_instr", bus.dec_instr, 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nx();
    chk("rs_c1_addr", bus.imem_addr, 32'h0);
    chk("rs_c1_req", 32'(bus.imem_req), 1);
    nx();
    chk("rs_c2_valid", 32'(bus.dec_valid), 0);
    nx();
    chk("rs_c3_pc", bus.dec_pc, 32'h0);
    chk("rs_c3_valid", 32'(bus.dec_valid), 1);
    nx();
    chk("rs_c4_pc", bus.dec_pc, 32'h4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
